conv_tile_instgen: RTL

//  Parametrised successor of the conv instruction generator. Walks a conv layer as output row (oy),

---
 rtl/conv_tile_instgen_if.sv | 34 +++
 rtl/conv_tile_instgen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_instgen_if.sv
// Instruction channel from the conv tile instruction generator to the decoder.
// The generator drives the payload and inst_valid; the decoder drives decoder_ready.
interface conv_tile_instgen_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned XLEN       = 32
);
    logic                  inst_valid;
    logic                  decoder_ready;
    logic [ADDR_WIDTH-1:0] inst_feature_addr;
    logic [ADDR_WIDTH-1:0] inst_kernel_addr;
    logic [ADDR_WIDTH-1:0] inst_wb_addr;
    logic [XLEN-1:0]       inst_chout;
    logic [XLEN-1:0]       inst_chin;
    logic [XLEN-1:0]       inst_kh;
    logic [XLEN-1:0]       inst_kw;
    logic [XLEN-1:0]       inst_w;
    logic                  inst_has_bias;
    logic                  inst_has_relu;
    logic                  inst_last;

    modport master (
        output inst_valid, inst_feature_addr, inst_kernel_addr, inst_wb_addr,
               inst_chout, inst_chin, inst_kh, inst_kw, inst_w,
               inst_has_bias, inst_has_relu, inst_last,
        input  decoder_ready
    );

    modport slave (
        input  inst_valid, inst_feature_addr, inst_kernel_addr, inst_wb_addr,
               inst_chout, inst_chin, inst_kh, inst_kw, inst_w,
               inst_has_bias, inst_has_relu, inst_last,
        output decoder_ready
    );
endinterface

// File: rtl/conv_tile_instgen.sv
// Conv layer instruction generator: walks (oy, ox, grp) and emits one instruction per step,
// with running-adder address generation, partial last channel group, abort and config checks.
module conv_tile_instgen #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_PE     = 8,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] feature_baseaddr,
    input  logic [ADDR_WIDTH-1:0] kernel_baseaddr,
    input  logic [ADDR_WIDTH-1:0] output_baseaddr,
    input  logic [XLEN-1:0]       feature_width,
    input  logic [XLEN-1:0]       feature_chin,
    input  logic [XLEN-1:0]       feature_chout,
    input  logic [XLEN-1:0]       kernel_sizeh,
    input  logic [XLEN-1:0]       kernel_sizew,
    input  logic [XLEN-1:0]       stride,
    input  logic [XLEN-1:0]       output_width,
    input  logic [XLEN-1:0]       output_height,
    input  logic                  has_bias,
    input  logic                  has_relu,
    input  logic                  csrcmd_valid,
    output logic                  instgen_ready,
    input  logic                  abort,
    conv_tile_instgen_if.master   inst,
    output logic                  conv_complete,
    output logic                  cfg_error,
    output logic [CNT_WIDTH-1:0]  inst_count
);

    localparam int unsigned PE_SHIFT = (NUM_PE > 1) ? $clog2(NUM_PE) : 0;
    localparam logic [XLEN-1:0] PE_MASK = XLEN'(NUM_PE - 1);
    localparam logic [XLEN-1:0] PE_X    = XLEN'(NUM_PE);
    localparam logic [ADDR_WIDTH-1:0] PE_A = ADDR_WIDTH'(NUM_PE);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ISSUE, S_DONE} state_t;
    state_t state_q, state_d;

    // latched layer configuration
    logic [ADDR_WIDTH-1:0] fbase_q, kbase_q, obase_q;
    logic [XLEN-1:0]       w_q, ci_q, co_q, kh_q, kw_q, s_q, ow_q, oh_q;
    logic                  bias_q, relu_q;

    // precomputed steps and walk state
    logic [ADDR_WIDTH-1:0] row_step_q, col_step_q, kgrp_step_q;
    logic [XLEN-1:0]       ngrp_q, grp_q, ox_q, oy_q, rem_q;
    logic [ADDR_WIDTH-1:0] row_addr_q, pix_wb_q;
    logic                  err_q;

    // registered instruction payload
    logic                  valid_q, last_q;
    logic [ADDR_WIDTH-1:0] feat_q, kern_q, wb_q;
    logic [XLEN-1:0]       chout_q;

    logic                  xfer_c, cfg_bad_c, grp_wrap_c, ox_wrap_c, last_n_c, first_last_c;
    logic [XLEN-1:0]       ngrp_c, grp_n_c, ox_n_c, oy_n_c;
    logic [ADDR_WIDTH-1:0] row_step_c, col_step_c, kgrp_step_c, row_n_c, pix_wb_n_c;

    function automatic logic [XLEN-1:0] min_pe(input logic [XLEN-1:0] r);
        return (r >= PE_X) ? PE_X : r;
    endfunction

    assign xfer_c = valid_q & inst.decoder_ready;

    // setup-time products and group count; the only multiplies in the design
    always_comb begin
        cfg_bad_c    = (ow_q == '0) || (oh_q == '0) || (co_q == '0) || (ci_q == '0) ||
                       (kh_q == '0) || (kw_q == '0) || (s_q == '0);
        row_step_c   = ADDR_WIDTH'(s_q) * ADDR_WIDTH'(w_q) * ADDR_WIDTH'(ci_q);
        col_step_c   = ADDR_WIDTH'(s_q) * ADDR_WIDTH'(ci_q);
        kgrp_step_c  = PE_A * ADDR_WIDTH'(kh_q) * ADDR_WIDTH'(kw_q) * ADDR_WIDTH'(ci_q);
        ngrp_c       = (co_q >> PE_SHIFT) + XLEN'(|(co_q & PE_MASK));
        first_last_c = (ngrp_c == XLEN'(1)) && (ow_q == XLEN'(1)) && (oh_q == XLEN'(1));
    end

    // next walk position and whether it is the final instruction
    always_comb begin
        grp_wrap_c = (grp_q == ngrp_q - XLEN'(1));
        ox_wrap_c  = (ox_q == ow_q - XLEN'(1));
        grp_n_c    = grp_wrap_c ? '0 : grp_q + XLEN'(1);
        ox_n_c     = ox_q;
        oy_n_c     = oy_q;
        if (grp_wrap_c) begin
            if (ox_wrap_c) begin
                ox_n_c = '0;
                oy_n_c = oy_q + XLEN'(1);
            end else begin
                ox_n_c = ox_q + XLEN'(1);
            end
        end
        last_n_c   = (oy_n_c == oh_q - XLEN'(1)) && (ox_n_c == ow_q - XLEN'(1)) &&
                     (grp_n_c == ngrp_q - XLEN'(1));
        row_n_c    = row_addr_q + row_step_q;
        pix_wb_n_c = pix_wb_q + ADDR_WIDTH'(co_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (csrcmd_valid) state_d = S_SETUP;
            S_SETUP: state_d = (abort || cfg_bad_c) ? S_DONE : S_ISSUE;
            S_ISSUE: if (abort || (xfer_c && last_q)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            instgen_ready <= 1'b1;
            valid_q       <= 1'b0;
            conv_complete <= 1'b0;
            cfg_error     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instgen_ready <= (state_d == S_IDLE);
            valid_q       <= (state_d == S_ISSUE);
            conv_complete <= (state_d == S_DONE);
            // error flag is only being loaded on the SETUP edge, so use the live check there
            cfg_error     <= (state_d == S_DONE) && ((state_q == S_SETUP) ? cfg_bad_c : err_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {fbase_q, kbase_q, obase_q}             <= '0;
            {w_q, ci_q, co_q, kh_q, kw_q, s_q}      <= '0;
            {ow_q, oh_q}                            <= '0;
            {bias_q, relu_q, err_q}                 <= '0;
            {row_step_q, col_step_q, kgrp_step_q}   <= '0;
            {ngrp_q, grp_q, ox_q, oy_q, rem_q}      <= '0;
            {row_addr_q, pix_wb_q}                  <= '0;
            {feat_q, kern_q, wb_q, chout_q, last_q} <= '0;
            inst_count                              <= '0;
        end else begin
            if (state_q == S_IDLE && csrcmd_valid) begin
                fbase_q    <= feature_baseaddr;
                kbase_q    <= kernel_baseaddr;
                obase_q    <= output_baseaddr;
                w_q        <= feature_width;
                ci_q       <= feature_chin;
                co_q       <= feature_chout;
                kh_q       <= kernel_sizeh;
                kw_q       <= kernel_sizew;
                s_q        <= stride;
                ow_q       <= output_width;
                oh_q       <= output_height;
                bias_q     <= has_bias;
                relu_q     <= has_relu;
                inst_count <= '0;
            end
            if (state_q == S_SETUP) begin
                row_step_q  <= row_step_c;
                col_step_q  <= col_step_c;
                kgrp_step_q <= kgrp_step_c;
                ngrp_q      <= ngrp_c;
                err_q       <= cfg_bad_c;
                {grp_q, ox_q, oy_q} <= '0;
                rem_q       <= co_q;
                row_addr_q  <= fbase_q;
                pix_wb_q    <= obase_q;
                feat_q      <= fbase_q;
                kern_q      <= kbase_q;
                wb_q        <= obase_q;
                chout_q     <= min_pe(co_q);
                last_q      <= first_last_c;
            end
            if (xfer_c) begin
                inst_count <= inst_count + CNT_WIDTH'(1);
                grp_q      <= grp_n_c;
                ox_q       <= ox_n_c;
                oy_q       <= oy_n_c;
                last_q     <= last_n_c;
                if (!grp_wrap_c) begin
                    kern_q  <= kern_q + kgrp_step_q;
                    wb_q    <= wb_q + PE_A;
                    rem_q   <= rem_q - PE_X;
                    chout_q <= min_pe(rem_q - PE_X);
                end else begin
                    kern_q   <= kbase_q;
                    rem_q    <= co_q;
                    chout_q  <= min_pe(co_q);
                    pix_wb_q <= pix_wb_n_c;
                    wb_q     <= pix_wb_n_c;
                    if (ox_wrap_c) begin
                        row_addr_q <= row_n_c;
                        feat_q     <= row_n_c;
                    end else begin
                        feat_q <= feat_q + col_step_q;
                    end
                end
            end
        end
    end

    assign inst.inst_valid        = valid_q;
    assign inst.inst_feature_addr = feat_q;
    assign inst.inst_kernel_addr  = kern_q;
    assign inst.inst_wb_addr      = wb_q;
    assign inst.inst_chout        = chout_q;
    assign inst.inst_chin         = ci_q;
    assign inst.inst_kh           = kh_q;
    assign inst.inst_kw           = kw_q;
    assign inst.inst_w            = w_q;
    assign inst.inst_has_bias     = bias_q;
    assign inst.inst_has_relu     = relu_q;
    assign inst.inst_last         = last_q;

endmodule
